cam_frame_tx: RTL and testbench
===============================

// Module: cam_frame_tx
// PURPOSE
//  Camera-side transmitter: reads a 12-bit RGB444 frame from a VRAM read port and emits it
//  as a camera byte stream (pclk/vsync/href/data[7:0], 2 bytes per pixel).
//  Acts as a sensor emulator for camera capture loopback and as a frame export path.
//  Runs entirely in the system clock domain; pclk is generated as a divided clock output.
// PARAMETERS
//  IMG_H        128  active pixels per line (1..128)
//  IMG_V        128  active lines per frame (1..128)
//  PCLK_DIV     2    clk cycles per output byte (even, >=2)
//  H_BLANK      32   byte periods of href low after each active line
//  VSYNC_LINES  3    line periods with vsync high
//  V_BACK       17   blank line periods after vsync, before the first active line
//  V_FRONT      10   blank line periods after the last active line
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active high
//  start       in   1   1-clk pulse: begin a frame (ignored while busy)
//  cont        in   1   1 = continuous frames; sampled at each frame end
//  rd_addr     out  14  VRAM read address {line[6:0], pix[6:0]}
//  rd_data     in   12  VRAM read data {R[3:0],G[3:0],B[3:0]}, valid 1 clk after rd_addr
//  cam_pclk    out  1   byte clock: low for first PCLK_DIV/2 clks of a byte period, high for the rest
//  cam_vsync   out  1   frame sync, active high
//  cam_href    out  1   line valid, high during active bytes
//  cam_data    out  8   pixel byte
//  busy        out  1   high from accepted start until the frame (or continuous run) ends
//  frame_done  out  1   1-clk pulse at the end of each frame's V_FRONT
// BEHAVIOUR
//  - Reset: every output is 0 (rd_addr=0, cam_*=0, busy=0, frame_done=0); FSM -> IDLE.
//    Reset mid-frame aborts immediately, with no partial-line completion.
//  - tick: internal strobe, 1 clk in every PCLK_DIV. It is the clk on which cam_pclk falls.
//    cam_vsync, cam_href and cam_data change only on a tick clk, so they are stable at the cam_pclk rising edge.
//    In IDLE, cam_pclk is held at 0.
//  - Line period: LB = 2*IMG_H + H_BLANK ticks.
//    Active line = 2*IMG_H ticks with href=1, then H_BLANK ticks with href=0.
//  - Pixel n of line v: byte0 = {4'h0, R}, then byte1 = {G, B}. Data is from rd_addr={v[6:0],n[6:0]}.
//    The read is issued >=1 clk before the tick that presents byte0. rd_data is registered; its combinational value is never used.
//  - cam_data = 0 whenever href=0.
//  - FSM, with durations counted in ticks:
//    IDLE -start-> VSYNC (VSYNC_LINES*LB, vsync=1) -> VBACK (V_BACK*LB) -> ACTIVE (IMG_V lines) -> VFRONT (V_FRONT*LB)
//    -> end of frame: frame_done pulse; if cont=1 -> VSYNC, else -> IDLE.
//  - The vsync rising edge coincides with the first tick after start (1-2 clk start latency, implementation fixed).
//  - busy rises on the clk after an accepted start and falls on the clk frame_done pulses, only if cont=0.
//  - start while busy: ignored. start and frame_done on the same clk with cont=0: start ignored.
//  - cont deasserted mid-frame: the current frame completes, then IDLE.
//  - Counters: pix 0..IMG_H-1, line 0..IMG_V-1; no wrap-around beyond these values. rd_addr unused bits are 0 when IMG_* < 128.
// TESTING
//  1. Assert rst for 3 clks mid-line (cont=1) -> next clk: all outputs 0, busy=0; a later start gives a full frame from vsync.
//  2. IMG_H=4, IMG_V=2, PCLK_DIV=2, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; memory model rd_data=12'hF00|addr[7:0];
//     single start -> line1 bytes 0F,80,0F,81,0F,82,0F,83.
//  3. Same config -> vsync high for exactly 10 ticks, 2 href pulses of 8 ticks each, frame_done once, busy low afterwards.
//  4. Defaults with PCLK_DIV=4 -> cam_pclk period 4 clks at 50% duty; data/href changes only on cam_pclk falling edges;
//     128 href pulses of 256 bytes.
//  5. cont=1 for 2 frames, then drop cont -> exactly 3 frame_done pulses, vsync directly follows each V_FRONT, busy low after the 3rd.
//  6. start pulsed while busy, and start coincident with frame_done (cont=0) -> both ignored; rd_addr stays 0 in IDLE.

Source files
------------

// File: rtl/cam_frame_tx.sv
// Camera sensor emulator: streams a 12-bit RGB444 frame from a VRAM read port as a
// pclk/vsync/href/data byte stream, two bytes per pixel, all in the system clock domain.
module cam_frame_tx #(
  parameter int unsigned IMG_H       = 128,
  parameter int unsigned IMG_V       = 128,
  parameter int unsigned PCLK_DIV    = 2,
  parameter int unsigned H_BLANK     = 32,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  output logic [13:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned LB    = 2 * IMG_H + H_BLANK;
  localparam int unsigned HW    = $clog2(LB + 1);
  localparam int unsigned VMAX0 = (IMG_V > V_BACK) ? IMG_V : V_BACK;
  localparam int unsigned VMAX1 = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
  localparam int unsigned VMAX  = (VMAX0 > VMAX1) ? VMAX0 : VMAX1;
  localparam int unsigned VW    = $clog2(VMAX + 1);
  localparam int unsigned PW    = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;

  localparam logic [HW-1:0] HLast     = HW'(LB - 1);
  localparam logic [HW-1:0] HFetch0   = HW'(LB - 2);
  localparam logic [HW-1:0] HActive   = HW'(2 * IMG_H);
  localparam logic [HW-1:0] HFetchEnd = HW'(2 * IMG_H - 2);
  localparam logic [VW-1:0] VsLast    = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VbLast    = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VaLast    = VW'(IMG_V - 1);
  localparam logic [VW-1:0] VfLast    = VW'(V_FRONT - 1);
  localparam logic [PW-1:0] PLast     = PW'(PCLK_DIV - 1);
  localparam logic [PW-1:0] PHalf     = PW'(PCLK_DIV / 2);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StVsync  = 3'd1;
  localparam logic [2:0] StVback  = 3'd2;
  localparam logic [2:0] StActive = 3'd3;
  localparam logic [2:0] StVfront = 3'd4;

  logic [2:0]    state_q, st_n;
  logic [PW-1:0] ph_q, ph_n;
  logic [HW-1:0] hcnt_q, h_n;
  logic [VW-1:0] vcnt_q, v_n;
  logic [11:0]   rd_q;
  logic [7:0]    hold_q, data_n;
  logic [13:0]   addr_n;
  logic          tick, frame_end, href_n, addr_load;

  // Next byte position, evaluated for use on a tick. V_BACK, V_FRONT, VSYNC_LINES assumed >= 1.
  always_comb begin
    tick      = (state_q != StIdle) && (ph_q == PLast);
    ph_n      = tick ? '0 : ph_q + PW'(1);
    h_n       = hcnt_q + HW'(1);
    v_n       = vcnt_q;
    st_n      = state_q;
    frame_end = 1'b0;
    if (hcnt_q == HLast) begin
      h_n = '0;
      v_n = vcnt_q + VW'(1);
      case (state_q)
        StVsync:  if (vcnt_q == VsLast) begin st_n = StVback;  v_n = '0; end
        StVback:  if (vcnt_q == VbLast) begin st_n = StActive; v_n = '0; end
        StActive: if (vcnt_q == VaLast) begin st_n = StVfront; v_n = '0; end
        StVfront: if (vcnt_q == VfLast) begin
          st_n      = StVsync;
          v_n       = '0;
          frame_end = 1'b1;
        end
        default: ;
      endcase
    end

    href_n = (st_n == StActive) && (h_n < HActive);
    data_n = 8'h00;
    if (href_n) data_n = h_n[0] ? hold_q : {4'h0, rd_q[11:8]};

    // Fetch each pixel two byte periods before its first byte; pixel 0 is fetched in the
    // preceding line's blanking.
    addr_load = 1'b0;
    addr_n    = '0;
    if ((st_n == StActive) && !h_n[0] && (h_n < HFetchEnd)) begin
      addr_load = 1'b1;
      addr_n    = {7'(v_n), 7'(h_n >> 1) + 7'd1};
    end else if (h_n == HFetch0) begin
      if ((st_n == StActive) && (v_n != VaLast)) begin
        addr_load = 1'b1;
        addr_n    = {7'(v_n) + 7'd1, 7'd0};
      end else if ((st_n == StVback) && (v_n == VbLast)) begin
        addr_load = 1'b1;
        addr_n    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ph_q       <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      rd_q       <= '0;
      hold_q     <= '0;
      rd_addr    <= '0;
      cam_pclk   <= 1'b0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rd_q       <= rd_data;
      frame_done <= 1'b0;
      if (state_q == StIdle) begin
        // A start landing on the frame_done clk is ignored.
        if (start && !frame_done) begin
          state_q   <= StVsync;
          busy      <= 1'b1;
          cam_vsync <= 1'b1;
          ph_q      <= '0;
          hcnt_q    <= '0;
          vcnt_q    <= '0;
        end
      end else begin
        ph_q     <= ph_n;
        cam_pclk <= (ph_n >= PHalf);
        if (tick) begin
          frame_done <= frame_end;
          if (frame_end && !cont) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            ph_q      <= '0;
            cam_pclk  <= 1'b0;
            cam_vsync <= 1'b0;
            cam_href  <= 1'b0;
            cam_data  <= '0;
            rd_addr   <= '0;
          end else begin
            state_q   <= st_n;
            hcnt_q    <= h_n;
            vcnt_q    <= v_n;
            cam_vsync <= (st_n == StVsync);
            cam_href  <= href_n;
            cam_data  <= data_n;
            if (href_n && !h_n[0]) hold_q <= rd_q[7:0];
            if (addr_load) rd_addr <= addr_n;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_tx.sv
// Bench for cam_frame_tx: two configurations checked every clk against a position-arithmetic
// model, plus literal expectations for sync timing, href pulse shape and pixel bytes.
module tb_cam_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] st  = 2'b00;
  logic [1:0] ct  = 2'b00;

  logic [13:0] ra0, ra1;
  logic [11:0] rdd0, rdd1;
  logic        pclk0, vs0, hr0, busy0, done0;
  logic        pclk1, vs1, hr1, busy1, done1;
  logic [7:0]  dat0, dat1;

  // Config 0: small frame, PCLK_DIV=2.  Config 1: PCLK_DIV=4, 50% duty.
  int c_h   [2] = '{4, 8};
  int c_v   [2] = '{2, 4};
  int c_div [2] = '{2, 4};
  int c_hb  [2] = '{2, 3};
  int c_vs  [2] = '{1, 2};
  int c_vb  [2] = '{1, 2};
  int c_vf  [2] = '{1, 2};

  cam_frame_tx #(.IMG_H(4), .IMG_V(2), .PCLK_DIV(2), .H_BLANK(2), .VSYNC_LINES(1), .V_BACK(1),
                 .V_FRONT(1)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .cont(ct[0]), .rd_addr(ra0), .rd_data(rdd0),
    .cam_pclk(pclk0), .cam_vsync(vs0), .cam_href(hr0), .cam_data(dat0), .busy(busy0),
    .frame_done(done0)
  );

  cam_frame_tx #(.IMG_H(8), .IMG_V(4), .PCLK_DIV(4), .H_BLANK(3), .VSYNC_LINES(2), .V_BACK(2),
                 .V_FRONT(2)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .cont(ct[1]), .rd_addr(ra1), .rd_data(rdd1),
    .cam_pclk(pclk1), .cam_vsync(vs1), .cam_href(hr1), .cam_data(dat1), .busy(busy1),
    .frame_done(done1)
  );

  function automatic logic [11:0] mem(input int i, input logic [13:0] a);
    if (i == 0) return 12'hF00 | {4'h0, a[7:0]};
    return a[11:0] ^ 12'hA5C ^ {10'h0, a[13:12]};
  endfunction

  // Synchronous VRAM: data appears one clk after the address.
  always_ff @(posedge clk) begin
    rdd0 <= mem(0, ra0);
    rdd1 <= mem(1, ra1);
  end

  logic [12:0] obs [2];
  logic [13:0] raddr [2];
  assign obs[0]   = {busy0, done0, pclk0, vs0, hr0, dat0};
  assign obs[1]   = {busy1, done1, pclk1, vs1, hr1, dat1};
  assign raddr[0] = ra0;
  assign raddr[1] = ra1;

  // {pclk, vsync, href, data} for clk c counted from the frame's first tick.
  function automatic logic [10:0] exp_io(input int i, input int c);
    int lb, k, line, h, a;
    logic [11:0] w;
    logic hr;
    logic [7:0] d;
    lb   = 2 * c_h[i] + c_hb[i];
    k    = c / c_div[i];
    line = k / lb;
    h    = k % lb;
    a    = line - c_vs[i] - c_vb[i];
    hr   = (a >= 0) && (a < c_v[i]) && (h < 2 * c_h[i]);
    w    = mem(i, {7'(a), 7'(h / 2)});
    d    = !hr ? 8'h00 : ((h % 2) == 0) ? {4'h0, w[11:8]} : w[7:0];
    return {((c % c_div[i]) >= (c_div[i] / 2)), (line < c_vs[i]), hr, d};
  endfunction

  function automatic int frame_clks(input int i);
    return (c_vs[i] + c_vb[i] + c_v[i] + c_vf[i]) * (2 * c_h[i] + c_hb[i]) * c_div[i];
  endfunction

  bit m_busy [2] = '{1'b0, 1'b0};
  bit m_done [2] = '{1'b0, 1'b0};
  int m_c    [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_c[i]    = 0;
      end else if (!m_busy[i]) begin
        if (st[i] && !m_done[i]) begin
          m_busy[i] = 1'b1;
          m_c[i]    = 0;
        end
        m_done[i] = 1'b0;
      end else begin
        m_c[i]    = m_c[i] + 1;
        m_done[i] = 1'b0;
        if (m_c[i] == frame_clks(i)) begin
          m_done[i] = 1'b1;
          m_c[i]    = 0;
          if (!ct[i]) m_busy[i] = 1'b0;
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int n_vs [2], n_done [2], viol [2], run [2];
  int hl0 [$];
  int hl1 [$];
  logic [7:0] bytes0 [$];
  logic [12:0] prev [2] = '{13'h0, 13'h0};

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      n_vs[i] = 0; n_done[i] = 0; viol[i] = 0; run[i] = 0;
    end
    hl0.delete();
    hl1.delete();
    bytes0.delete();
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [12:0] expv;
      expv = {m_busy[i], m_done[i], (m_busy[i] ? exp_io(i, m_c[i]) : 11'h0)};
      n_chk++;
      if (obs[i] !== expv) begin
        n_err++;
        $display("FAIL dut%0d outputs t=%0t got=%h expected=%h (busy,done,pclk,vsync,href,data)",
                 i, $time, obs[i], expv);
      end
      if (!m_busy[i]) begin
        n_chk++;
        if (raddr[i] !== 14'h0) begin
          n_err++;
          $display("FAIL dut%0d idle_rd_addr t=%0t got=%h expected=0", i, $time, raddr[i]);
        end
      end
      if (obs[i][11]) n_done[i]++;
      if (obs[i][10] && !prev[i][10]) begin
        if (obs[i][9]) n_vs[i]++;
        if (obs[i][8]) begin
          run[i]++;
          if (i == 0) bytes0.push_back(obs[i][7:0]);
        end else if (run[i] > 0) begin
          if (i == 0) hl0.push_back(run[i]);
          else hl1.push_back(run[i]);
          run[i] = 0;
        end
      end
      if ((obs[i][9:0] != prev[i][9:0]) && !(!obs[i][10] && (prev[i][10] || !prev[i][12])))
        viol[i]++;
      prev[i] = obs[i];
    end
  end

  task automatic pulse(input int i);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (obs[i][11]) seen = 1'b1;
    end
    chk("frame_done_wait", int'(seen), 1);
  endtask

  logic [7:0] exp_l1 [8] = '{8'h0F, 8'h80, 8'h0F, 8'h81, 8'h0F, 8'h82, 8'h0F, 8'h83};

  initial begin
    clr();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", int'(busy0), 0);
    chk("reset_pclk", int'(pclk1), 0);
    chk("reset_addr", int'(ra1), 0);

    // Single frame on config 0, with a start while busy and a start on the frame_done clk.
    repeat (3) @(negedge clk);
    clr();
    pulse(0);
    repeat (20) @(negedge clk);
    pulse(0);
    wait_done(0, 400);
    pulse(0);
    repeat (10) @(negedge clk);
    chk("a_vsync_ticks", n_vs[0], 10);
    chk("a_href_pulses", hl0.size(), 2);
    foreach (hl0[j]) chk("a_href_len", hl0[j], 8);
    chk("a_frame_done_count", n_done[0], 1);
    chk("a_busy_after", int'(busy0), 0);
    chk("a_addr_idle", int'(ra0), 0);
    chk("a_byte_count", bytes0.size(), 16);
    for (int j = 0; j < 8; j++)
      if (8 + j < bytes0.size()) chk("a_line1_byte", int'(bytes0[8 + j]), int'(exp_l1[j]));

    // Continuous run: two frames with cont=1, then drop it.
    clr();
    ct[0] = 1'b1;
    pulse(0);
    wait_done(0, 300);
    wait_done(0, 300);
    ct[0] = 1'b0;
    wait_done(0, 300);
    repeat (5) @(negedge clk);
    chk("cont_frame_done_count", n_done[0], 3);
    chk("cont_vsync_ticks", n_vs[0], 30);
    chk("cont_busy_after", int'(busy0), 0);

    // Reset mid-line, then a fresh frame.
    clr();
    ct[0] = 1'b1;
    pulse(0);
    repeat (45) @(negedge clk);
    chk("midline_href", int'(hr0), 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    ct[0] = 1'b0;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_data", int'(dat0), 0);
    chk("rst_vsync", int'(vs0), 0);
    repeat (3) @(negedge clk);
    clr();
    pulse(0);
    wait_done(0, 300);
    repeat (5) @(negedge clk);
    chk("rst_refr_vsync_ticks", n_vs[0], 10);
    chk("rst_refr_href_pulses", hl0.size(), 2);
    chk("rst_refr_done_count", n_done[0], 1);

    // Config 1: PCLK_DIV=4.
    clr();
    pulse(1);
    wait_done(1, 2000);
    repeat (10) @(negedge clk);
    chk("b_vsync_ticks", n_vs[1], 38);
    chk("b_href_pulses", hl1.size(), 4);
    foreach (hl1[j]) chk("b_href_len", hl1[j], 16);
    chk("b_off_edge_changes", viol[1], 0);
    chk("b_frame_done_count", n_done[1], 1);
    chk("b_busy_after", int'(busy1), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
